// File: rtl/axi_req_arbiter.sv
// Round-robin packet arbiter merging NUM_REQ FLIT-format AXI4-Stream request sources
// into one registered output stage; grants move only on packet boundaries.
module axi_req_arbiter #(
  parameter int FPW     = 4,
  parameter int NUM_REQ = 2,
  parameter int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [NUM_REQ-1:0]         s_TVALID,
  output logic [NUM_REQ-1:0]         s_TREADY,
  input  logic [NUM_REQ*FPW*128-1:0] s_TDATA,
  input  logic [NUM_REQ*FPW*16-1:0]  s_TUSER,
  output logic                       m_TVALID,
  input  logic                       m_TREADY,
  output logic [FPW*128-1:0]         m_TDATA,
  output logic [FPW*16-1:0]          m_TUSER,
  output logic [RW-1:0]              grant_id,
  output logic                       locked
);

  localparam int DW = FPW * 128;
  localparam int UW = FPW * 16;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   ptr, ptr_nxt, grant_nxt;
  logic [RW-1:0]   sel;
  logic            sel_any;
  logic            ld;
  logic            accept;
  logic [DW-1:0]   sel_data;
  logic [UW-1:0]   sel_user;
  logic            pkt_found;
  logic            pkt_close;

  function automatic logic [RW-1:0] next_idx(input logic [RW-1:0] i);
    return (i == RW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign ld     = !m_TVALID || m_TREADY;
  assign locked = (state == LOCK);
  assign accept = |(s_TREADY & s_TVALID);

  // Source selection: locked grant wins; otherwise first valid at or after ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    int idx;
    idx     = 0;
    sel     = grant_id;
    sel_any = 1'b0;
    if (state == LOCK) begin
      sel_any = 1'b1;
    end else begin
      // Descending scan so the nearest candidate to ptr is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (s_TVALID[RW'(idx)]) begin
          sel     = RW'(idx);
          sel_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_TREADY = '0;
    sel_data = '0;
    sel_user = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == RW'(i)) begin
        sel_data = s_TDATA[i*DW +: DW];
        sel_user = s_TUSER[i*UW +: UW];
        s_TREADY[i] = res && ld && sel_any;
      end
    end
  end

  // The highest valid FLIT carrying Hdr or Tail decides whether the packet ends open.
  always_comb begin
    pkt_found = 1'b0;
    pkt_close = 1'b0;
    for (int f = 0; f < FPW; f++) begin
      if (sel_user[f] && (sel_user[FPW+f] || sel_user[2*FPW+f])) begin
        pkt_found = 1'b1;
        pkt_close = sel_user[2*FPW+f];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    if (accept) begin
      case (state)
        IDLE: begin
          grant_nxt = sel;
          if (pkt_found) begin
            if (pkt_close) ptr_nxt   = next_idx(sel);
            else           state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (pkt_found && pkt_close) begin
            state_nxt = IDLE;
            ptr_nxt   = next_idx(grant_id);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  // Data holds when no beat is loaded; its reset value is visible on the port.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      m_TVALID <= 1'b0;
      m_TDATA  <= '0;
      m_TUSER  <= '0;
    end else if (accept) begin
      m_TVALID <= 1'b1;
      m_TDATA  <= sel_data;
      m_TUSER  <= sel_user;
    end else if (ld) begin
      m_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed, table-driven bench for axi_req_arbiter (FPW=4, NUM_REQ=2), plus a
// hand-written mid-packet reset sequence.
module tb_axi_req_arbiter;

  localparam int FPW = 4;
  localparam int NR  = 2;
  localparam int DW  = FPW * 128;
  localparam int UW  = FPW * 16;

  logic               clk;
  logic               res;
  logic [NR-1:0]      s_TVALID;
  logic [NR-1:0]      s_TREADY;
  logic [NR*DW-1:0]   s_TDATA;
  logic [NR*UW-1:0]   s_TUSER;
  logic               m_TVALID;
  logic               m_TREADY;
  logic [DW-1:0]      m_TDATA;
  logic [UW-1:0]      m_TUSER;
  logic [0:0]         grant_id;
  logic               locked;

  axi_req_arbiter #(.FPW(FPW), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .res      (res),
    .s_TVALID (s_TVALID),
    .s_TREADY (s_TREADY),
    .s_TDATA  (s_TDATA),
    .s_TUSER  (s_TUSER),
    .m_TVALID (m_TVALID),
    .m_TREADY (m_TREADY),
    .m_TDATA  (m_TDATA),
    .m_TUSER  (m_TUSER),
    .grant_id (grant_id),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle and the outputs expected during that cycle
  // (before the edge that samples the inputs). f = {tail, hdr, valid}; e_tag 0 = no data check.
  typedef struct {
    logic [1:0]  v;
    logic [7:0]  t0;
    logic [11:0] f0;
    logic [7:0]  t1;
    logic [11:0] f1;
    logic        mr;
    logic [1:0]  e_rdy;
    logic        e_lock;
    logic        e_gid;
    logic        e_mv;
    logic [7:0]  e_tag;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] user_of [256];
  int          checks;
  int          errors;

  function automatic logic [63:0] mk_user(input logic [7:0] tag, input logic [11:0] f);
    return {tag, 44'd0, f};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
    return {64{tag}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] t0, input logic [11:0] f0,
                       input logic [7:0] t1, input logic [11:0] f1, input logic mr);
    user_of[t0] = mk_user(t0, f0);
    user_of[t1] = mk_user(t1, f1);
    s_TVALID    = v;
    s_TDATA     = {mk_data(t1), mk_data(t0)};
    s_TUSER     = {mk_user(t1, f1), mk_user(t0, f0)};
    m_TREADY    = mr;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    res      = 1'b0;
    s_TVALID = '0;
    s_TDATA  = '0;
    s_TUSER  = '0;
    m_TREADY = 1'b1;

    //            v      t0     f0       t1     f1       mr    rdy    lk    gid   mv    tag
    vecs.push_back('{2'b11, 8'h01, 12'h111, 8'h81, 12'h111, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{2'b11, 8'h02, 12'h111, 8'h82, 12'h111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h01});
    vecs.push_back('{2'b11, 8'h03, 12'h111, 8'h83, 12'h111, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h82});
    vecs.push_back('{2'b11, 8'h04, 12'h111, 8'h84, 12'h111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h03});
    // 3-beat packet on source 0 while source 1 stays valid
    vecs.push_back('{2'b11, 8'h10, 12'h011, 8'h90, 12'h111, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h84});
    vecs.push_back('{2'b11, 8'h11, 12'h00F, 8'h91, 12'h111, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h10});
    vecs.push_back('{2'b11, 8'h12, 12'h407, 8'h92, 12'h111, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h11});
    vecs.push_back('{2'b11, 8'h13, 12'h111, 8'h93, 12'h111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h12});
    // sparse source 1 with ptr = 0, then Tail FLIT1 + Hdr FLIT3 keeps the lock
    vecs.push_back('{2'b10, 8'h14, 12'h111, 8'hA0, 12'h011, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h93});
    vecs.push_back('{2'b11, 8'h15, 12'h111, 8'hA1, 12'h28F, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hA0});
    vecs.push_back('{2'b11, 8'h16, 12'h111, 8'hA2, 12'h101, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hA1});
    vecs.push_back('{2'b11, 8'h17, 12'h111, 8'hA3, 12'h111, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'hA2});
    // locked source drops valid mid-packet: bubbles, source 1 stays blocked
    vecs.push_back('{2'b11, 8'h20, 12'h011, 8'hB0, 12'h111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h17});
    vecs.push_back('{2'b11, 8'h20, 12'h011, 8'hB1, 12'h111, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'hB0});
    vecs.push_back('{2'b10, 8'h21, 12'h011, 8'hB2, 12'h111, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h20});
    vecs.push_back('{2'b10, 8'h22, 12'h011, 8'hB3, 12'h111, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h20});
    vecs.push_back('{2'b11, 8'h23, 12'h101, 8'hB4, 12'h111, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h20});
    vecs.push_back('{2'b11, 8'h24, 12'h111, 8'hB5, 12'h111, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h23});
    // backpressure for 3 cycles
    vecs.push_back('{2'b11, 8'h25, 12'h111, 8'hB6, 12'h111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hB5});
    vecs.push_back('{2'b11, 8'h26, 12'h111, 8'hB7, 12'h111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hB5});
    vecs.push_back('{2'b11, 8'h27, 12'h111, 8'hB8, 12'h111, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hB5});
    vecs.push_back('{2'b11, 8'h28, 12'h111, 8'hB9, 12'h111, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'hB5});
    // no requesters: output drains, data is held
    vecs.push_back('{2'b00, 8'h29, 12'h111, 8'hBA, 12'h111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h28});
    vecs.push_back('{2'b00, 8'h2A, 12'h111, 8'hBB, 12'h111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h28});

    // Reset state
    #3;
    check("rst_mvalid", DW'(m_TVALID), DW'(1'b0));
    check("rst_tready", DW'(s_TREADY), DW'(2'b00));
    check("rst_gid",    DW'(grant_id), DW'(1'b0));
    check("rst_locked", DW'(locked),   DW'(1'b0));
    check("rst_mdata",  m_TDATA,       '0);
    check("rst_muser",  DW'(m_TUSER),  '0);
    @(negedge clk);
    res = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].t0, vecs[i].f0, vecs[i].t1, vecs[i].f1, vecs[i].mr);
      #1;
      check($sformatf("row%0d_tready", i), DW'(s_TREADY), DW'(vecs[i].e_rdy));
      check($sformatf("row%0d_locked", i), DW'(locked),   DW'(vecs[i].e_lock));
      check($sformatf("row%0d_gid", i),    DW'(grant_id), DW'(vecs[i].e_gid));
      check($sformatf("row%0d_mvalid", i), DW'(m_TVALID), DW'(vecs[i].e_mv));
      if (vecs[i].e_tag != 8'h00) begin
        check($sformatf("row%0d_mdata", i), m_TDATA,      mk_data(vecs[i].e_tag));
        check($sformatf("row%0d_muser", i), DW'(m_TUSER), DW'(user_of[vecs[i].e_tag]));
      end
      @(negedge clk);
    end

    // Lock source 1, then reset mid-packet
    drive(2'b10, 8'hC3, 12'h111, 8'hC0, 12'h011, 1'b1);
    #1;
    check("seq_lock1_tready", DW'(s_TREADY), DW'(2'b10));
    @(negedge clk);
    drive(2'b11, 8'hC1, 12'h111, 8'hC2, 12'h00F, 1'b1);
    #1;
    check("seq_locked", DW'(locked),   DW'(1'b1));
    check("seq_gid1",   DW'(grant_id), DW'(1'b1));
    check("seq_tready_locked", DW'(s_TREADY), DW'(2'b10));
    #1;
    res = 1'b0;
    #1;
    check("mrst_mvalid", DW'(m_TVALID), DW'(1'b0));
    check("mrst_tready", DW'(s_TREADY), DW'(2'b00));
    check("mrst_gid",    DW'(grant_id), DW'(1'b0));
    check("mrst_locked", DW'(locked),   DW'(1'b0));
    check("mrst_mdata",  m_TDATA,       '0);
    check("mrst_muser",  DW'(m_TUSER),  '0);
    @(posedge clk);
    #1;
    check("mrst_hold_tready", DW'(s_TREADY), DW'(2'b00));
    check("mrst_hold_mvalid", DW'(m_TVALID), DW'(1'b0));
    @(negedge clk);
    res = 1'b1;
    #1;
    check("post_rst_tready", DW'(s_TREADY), DW'(2'b01));
    @(negedge clk);
    drive(2'b00, 8'hC4, 12'h111, 8'hC5, 12'h111, 1'b1);
    #1;
    check("post_rst_mvalid", DW'(m_TVALID), DW'(1'b1));
    check("post_rst_mdata",  m_TDATA,       mk_data(8'hC1));
    check("post_rst_gid",    DW'(grant_id), DW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
# axi_req_arbiter

Round-robin packet arbiter that merges NUM_REQ AXI4-Stream request sources into the single request stream feeding the HMC controller's AXI request port. Each source uses the FLIT format: TDATA = FPW×128 bits, TUSER = FPW×16 bits, with Valid/Hdr/Tail flags in TUSER[FPW-1:0], [2FPW-1:FPW] and [3FPW-1:2FPW]. Grants change only on packet boundaries. The output is a single registered pipeline stage sustaining one beat per cycle.

## Interface
- FPW, 4, FLITs per beat (2, 4, 6 or 8)
- NUM_REQ, 2, number of requesters (2..8)
- RW, $clog2(NUM_REQ) (minimum 1), grant index width
- clk  in  1  clock, all logic on rising edge
- res  in  1  one clock; reset is asynchronous and active-low
- s_TVALID  in  NUM_REQ  per-requester beat valid
- s_TREADY  out  NUM_REQ  per-requester ready
- s_TDATA  in  NUM_REQ×FPW×128  requester i at slice i
- s_TUSER  in  NUM_REQ×FPW×16  requester i at slice i
- m_TVALID  out  1  output beat valid
- m_TREADY  in  1  controller ready
- m_TDATA  out  FPW×128  registered data
- m_TUSER  out  FPW×16  registered user flags
- grant_id  out  RW  requester currently granted or last granted
- locked  out  1  high while a packet is open on the granted requester

## Operation
- **Load enable:** ld = !m_TVALID || m_TREADY.
- **Accept:** requester g is accepted when s_TREADY[g] && s_TVALID[g]. s_TREADY[i] = ld && (i == selected source). At most one bit of s_TREADY is high.
- **States:**
  - IDLE: the selected source is the first i with s_TVALID[i], searched from ptr upward mod NUM_REQ. If none, no source is selected.
  - LOCK: the selected source is grant_id, regardless of other valids.
- **Packet-state update** on each accepted beat, from its TUSER:
  - Consider valid FLITs only (Valid bit = 1). Find the highest FLIT index carrying Hdr or Tail.
  - Tail set at that FLIT (including Hdr+Tail, a 1-FLIT packet): packet closed.
  - Hdr only at that FLIT: packet open.
  - No Hdr/Tail on any valid FLIT: state unchanged.
- **Transitions:**
  - IDLE: an accept from g sets grant_id = g. If the beat leaves the packet open, go to LOCK. If it closes, stay in IDLE and set ptr = (g+1) mod NUM_REQ.
  - LOCK: a closing beat returns to IDLE with ptr = (grant_id+1) mod NUM_REQ. Any other beat stays in LOCK.
  - An accepted beat in IDLE with no Hdr/Tail on any valid FLIT (stray payload) stays in IDLE and leaves ptr unchanged.
- **Output register:** on accept, m_TDATA/m_TUSER load from the source slice and m_TVALID = 1. On ld with no accept, m_TVALID = 0; data is held, not cleared.
- **Pass-through:** beats are forwarded unmodified, including Valid = 0 FLITs.
- **Outputs:** locked = (state == LOCK).

## Timing
- **Reset (res = 0, asynchronous):**
  - State = IDLE, ptr = 0, grant_id = 0.
  - m_TVALID = 0, m_TDATA = 0, m_TUSER = 0, locked = 0.
  - s_TREADY is forced to all zeros while res = 0.
- **Latency:** a beat accepted at edge N appears on m_* after edge N (1 cycle).
- **Throughput:** one beat per cycle with m_TREADY held at 1.
- **Re-arbitration costs no bubble.** A closing beat at edge N allows a different requester to be accepted at edge N+1.
- **Handshake rule:** while m_TVALID && !m_TREADY, m_TDATA/m_TUSER/m_TVALID are stable and all s_TREADY = 0.
- **Simultaneous events:**
  - m_TREADY with a new accept in the same cycle: replace the output register, no gap.
  - Several valid requesters in IDLE: pointer order decides; only one is accepted.
- **Locked source drops s_TVALID mid-packet:** stay in LOCK, with output bubbles until it resumes. Other requesters stay blocked.
- **Reset mid-packet:** everything returns to its reset value immediately. The partial packet is discarded downstream responsibility; no recovery logic.
- **Source independence:** requester TVALID/TDATA are not required to be stable before acceptance. The arbiter samples them only at the accept edge.

## Test plan
- **Reset:** assert res = 0 mid-traffic → m_TVALID = 0, s_TREADY = 0, grant_id = 0, locked = 0 within the same cycle. First accept after release comes from requester 0 when all are valid.
- **Fairness:** NUM_REQ = 2, both sources stream 1-beat packets (Hdr = Tail = 4'b0001, Valid = 4'b0001), m_TREADY = 1 → accept order 0,1,0,1,… one per cycle. First m_TVALID one cycle after the first accept.
- **Packet lock:** requester 0 sends a 3-beat packet (beat 1 Hdr FLIT0, beat 2 no flags, beat 3 Tail FLIT2) while requester 1 is continuously valid → s_TREADY[1] = 0 for 3 cycles, locked = 1 after beat 1. Requester 1 is accepted the cycle after beat 3.
- **Mid-beat restart:** beat with Tail at FLIT1 and Hdr at FLIT3 → stays in LOCK. Next beat with Tail at FLIT0 → returns to IDLE and ptr advances.
- **Backpressure:** m_TREADY = 0 for 3 cycles with m_TVALID = 1 → m_TDATA/m_TUSER unchanged and all s_TREADY = 0. No beat is lost or duplicated; the output sequence matches the input order exactly.
- **Sparse sources:** requester 1 alone is valid with ptr = 0 → requester 1 is accepted in the same cycle and ptr becomes 0 after its closing beat.
